// File: rtl/hazard_scoreboard_r0_if.sv
// hazard_scoreboard_r0_if: ID/WB register-write requests into the scoreboard and its status back out.
interface hazard_scoreboard_r0_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PERF_WIDTH = 16
);
    logic id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic id_useRs;
    logic id_useRt;
    logic id_writeReg;
    logic id_longLat;
    logic [REG_ADDR_WIDTH-1:0] id_regToWrite;
    logic id_flush;
    logic wb_writeReg;
    logic wb_longLat;
    logic [REG_ADDR_WIDTH-1:0] wb_regToWrite;
    logic stall;
    logic pending_any;
    logic [PERF_WIDTH-1:0] stall_cycles;
    logic underflow_err;
    modport master (
        output id_valid, id_rs, id_rt, id_useRs, id_useRt, id_writeReg, id_longLat,
               id_regToWrite, id_flush, wb_writeReg, wb_longLat, wb_regToWrite,
        input  stall, pending_any, stall_cycles, underflow_err
    );
    modport slave (
        input  id_valid, id_rs, id_rt, id_useRs, id_useRt, id_writeReg, id_longLat,
               id_regToWrite, id_flush, wb_writeReg, wb_longLat, wb_regToWrite,
        output stall, pending_any, stall_cycles, underflow_err
    );
endinterface

// File: rtl/hazard_scoreboard_r0.sv
// hazard_scoreboard_r0: counts in-flight long-latency writes per register and stalls ID on unforwardable hazards.
module hazard_scoreboard_r0 #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH = 2,
    parameter int PERF_WIDTH = 16
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_r0_if.slave bus
);
    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_nxt [NUM_REGS];
    logic [PERF_WIDTH-1:0] stall_cycles;
    logic pending_any, underflow_err;
    logic retire, dest_write, rs_hazard, rt_hazard, dest_full, stall, issue, same, underflow, pend_nxt;
    logic [REG_ADDR_WIDTH-1:0] rd, wb;
    assign rd = bus.id_regToWrite;
    assign wb = bus.wb_regToWrite;
    assign retire = bus.wb_writeReg & bus.wb_longLat & (wb != '0);
    assign dest_write = bus.id_writeReg & bus.id_longLat & (rd != '0);
    // A final retire in the same cycle is covered by register-file write-through and WB forwarding.
    assign rs_hazard = (bus.id_rs != '0) & (cnt[bus.id_rs] != '0) &
                       !(retire & (wb == bus.id_rs) & (cnt[bus.id_rs] == CNT_ONE));
    assign rt_hazard = (bus.id_rt != '0) & (cnt[bus.id_rt] != '0) &
                       !(retire & (wb == bus.id_rt) & (cnt[bus.id_rt] == CNT_ONE));
    assign dest_full = dest_write & (cnt[rd] == CNT_MAX) & !(retire & (wb == rd));
    assign stall = bus.id_valid & !bus.id_flush &
                   ((bus.id_useRs & rs_hazard) | (bus.id_useRt & rt_hazard) | dest_full);
    assign issue = bus.id_valid & !bus.id_flush & !stall & dest_write;
    assign same = issue & retire & (rd == wb);
    assign underflow = retire & !same & (cnt[wb] == '0);
    always_comb begin
        cnt_nxt = cnt;
        pend_nxt = 1'b0;
        if (issue & !same) cnt_nxt[rd] = cnt[rd] + CNT_ONE;
        if (retire & !same) cnt_nxt[wb] = underflow ? '0 : cnt[wb] - CNT_ONE;
        cnt_nxt[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) pend_nxt = pend_nxt | (cnt_nxt[i] != '0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '{default: '0};
            pending_any <= 1'b0;
            stall_cycles <= '0;
            underflow_err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            pending_any <= pend_nxt;
            stall_cycles <= (stall & ~&stall_cycles) ? stall_cycles + PERF_WIDTH'(1) : stall_cycles;
            underflow_err <= underflow_err | underflow;
        end
    end
    assign bus.stall = stall;
    assign bus.pending_any = pending_any;
    assign bus.stall_cycles = stall_cycles;
    assign bus.underflow_err = underflow_err;
endmodule

// File: tb/tb_hazard_scoreboard_r0.sv
// tb_hazard_scoreboard_r0: directed stimulus, per-cycle comparison against a counting model of the scoreboard.
module tb_hazard_scoreboard_r0;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    hazard_scoreboard_r0_if #(.REG_ADDR_WIDTH(5), .PERF_WIDTH(16)) bus ();
    hazard_scoreboard_r0 #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2), .PERF_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    int checks = 0;
    int errors = 0;
    int mcnt [32];
    int m_sc = 0;
    bit m_pend = 0;
    bit m_uf = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic bit m_retire();
        return bus.wb_writeReg && bus.wb_longLat && bus.wb_regToWrite != 0;
    endfunction
    function automatic bit m_src(input int x);
        if (x == 0 || mcnt[x] == 0) return 0;
        return !(m_retire() && int'(bus.wb_regToWrite) == x && mcnt[x] == 1);
    endfunction
    function automatic bit exp_stall();
        int rd;
        bit full;
        rd = bus.id_regToWrite;
        full = bus.id_writeReg && bus.id_longLat && rd != 0 && mcnt[rd] == 3 &&
               !(m_retire() && int'(bus.wb_regToWrite) == rd);
        if (!bus.id_valid || bus.id_flush) return 0;
        return (bus.id_useRs && m_src(bus.id_rs)) || (bus.id_useRt && m_src(bus.id_rt)) || full;
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            m_pend = 0;
            m_sc = 0;
            m_uf = 0;
        end else begin
            bit st, ret, iss;
            int rd, wb;
            st = exp_stall();
            ret = m_retire();
            rd = bus.id_regToWrite;
            wb = bus.wb_regToWrite;
            iss = bus.id_valid && !bus.id_flush && !st && bus.id_writeReg && bus.id_longLat && rd != 0;
            if (st && m_sc < 65535) m_sc++;
            if (!(iss && ret && rd == wb)) begin
                if (iss) mcnt[rd]++;
                if (ret) begin
                    if (mcnt[wb] == 0) m_uf = 1;
                    else mcnt[wb]--;
                end
            end
            m_pend = 0;
            foreach (mcnt[i]) if (mcnt[i] != 0) m_pend = 1;
        end
    end
    always @(negedge clk) begin
        chk("stall", int'(bus.stall), int'(exp_stall()));
        chk("pending_any", int'(bus.pending_any), int'(m_pend));
        chk("stall_cycles", int'(bus.stall_cycles), m_sc);
        chk("underflow_err", int'(bus.underflow_err), int'(m_uf));
    end
    task automatic idle();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_useRs = 0; bus.id_useRt = 0;
        bus.id_writeReg = 0; bus.id_longLat = 0; bus.id_regToWrite = 0; bus.id_flush = 0;
        bus.wb_writeReg = 0; bus.wb_longLat = 0; bus.wb_regToWrite = 0;
    endtask
    task automatic load(input int rd);
        bus.id_valid = 1; bus.id_writeReg = 1; bus.id_longLat = 1; bus.id_regToWrite = 5'(rd);
    endtask
    task automatic read_rs(input int r);
        bus.id_valid = 1; bus.id_useRs = 1; bus.id_rs = 5'(r);
    endtask
    task automatic retire(input int r);
        bus.wb_writeReg = 1; bus.wb_longLat = 1; bus.wb_regToWrite = 5'(r);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask
    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", int'(bus.stall), 0);
        chk("rst_pending", int'(bus.pending_any), 0);
        chk("rst_stall_cycles", int'(bus.stall_cycles), 0);
        rst = 1;
        step();
        // load r8, dependent reader stalls three cycles, final retire releases it
        load(8); #1; chk("load8_stall", int'(bus.stall), 0); step();
        for (int i = 0; i < 3; i++) begin
            read_rs(8); #1; chk("raw8_stall", int'(bus.stall), 1); step();
        end
        read_rs(8); retire(8); #1; chk("raw8_retire_stall", int'(bus.stall), 0); step();
        chk("raw8_pending", int'(bus.pending_any), 0);
        chk("raw8_stall_cycles", int'(bus.stall_cycles), 3);
        // r0 is never tracked
        load(0); step();
        read_rs(0); #1; chk("r0_stall", int'(bus.stall), 0); step();
        chk("r0_pending", int'(bus.pending_any), 0);
        // saturate r5, then dest_full with and without a same-cycle retire
        for (int i = 0; i < 3; i++) begin
            load(5); #1; chk("r5_fill_stall", int'(bus.stall), 0); step();
        end
        chk("r5_model_cnt", mcnt[5], 3);
        chk("r5_pending", int'(bus.pending_any), 1);
        load(5); #1; chk("r5_full_stall", int'(bus.stall), 1); step();
        load(5); retire(5); #1; chk("r5_full_retire_stall", int'(bus.stall), 0); step();
        chk("r5_model_cnt_hold", mcnt[5], 3);
        repeat (3) begin retire(5); step(); end
        chk("r5_drained_pending", int'(bus.pending_any), 0);
        // simultaneous issue/retire on the same and on different registers
        load(9); step();
        load(10); step();
        load(9); retire(9); step();
        chk("r9_same_cnt", mcnt[9], 1);
        load(9); retire(10); step();
        chk("r9_cnt", mcnt[9], 2);
        chk("r10_cnt", mcnt[10], 0);
        read_rs(10); #1; chk("r10_free_stall", int'(bus.stall), 0); step();
        bus.id_valid = 1; bus.id_useRt = 1; bus.id_rt = 9; #1;
        chk("r9_rt_stall", int'(bus.stall), 1); step();
        repeat (2) begin retire(9); step(); end
        // underflow is sticky
        retire(12); step();
        chk("underflow_set", int'(bus.underflow_err), 1);
        step();
        chk("underflow_sticky", int'(bus.underflow_err), 1);
        // flush suppresses stall and issue
        load(8); step();
        read_rs(8); load(3); bus.id_flush = 1; #1;
        chk("flush_stall", int'(bus.stall), 0); step();
        chk("flush_no_issue", mcnt[3], 0);
        read_rs(3); #1; chk("flush_r3_stall", int'(bus.stall), 0);
        // asynchronous reset mid-cycle with cnt[8] = 1
        read_rs(8); #1;
        chk("pre_rst_stall", int'(bus.stall), 1);
        rst = 0; #1;
        chk("async_stall", int'(bus.stall), 0);
        chk("async_pending", int'(bus.pending_any), 0);
        chk("async_stall_cycles", int'(bus.stall_cycles), 0);
        chk("async_underflow", int'(bus.underflow_err), 0);
        step();
        rst = 1;
        read_rs(8); #1; chk("post_rst_stall", int'(bus.stall), 0); step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_r0.md
Name: hazard_scoreboard_r0

Overview:
- Producer-side companion to the EX-stage data forwarding logic.
- Tracks in-flight long-latency register writes (loads, mult/div results) from issue until writeback.
- Stalls the decode stage when a source register depends on a write whose value cannot yet be forwarded.
- Sits between ID and the pipeline control. It drives the stall that holds PC/IF/ID and bubbles ID/EX.

Parameters:
- REG_ADDR_WIDTH, 5, register address width; NUM_REGS = 2**REG_ADDR_WIDTH.
- CNT_WIDTH, 2, width of each per-register outstanding-write counter.
- PERF_WIDTH, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs  in  REG_ADDR_WIDTH  ID source register A.
- id_rt  in  REG_ADDR_WIDTH  ID source register B.
- id_useRs  in  1  instruction reads rs.
- id_useRt  in  1  instruction reads rt.
- id_writeReg  in  1  instruction writes a register.
- id_longLat  in  1  write is long-latency (load/mult/div).
- id_regToWrite  in  REG_ADDR_WIDTH  destination register.
- id_flush  in  1  squash ID instruction this cycle (branch/jump).
- wb_writeReg  in  1  WB stage writes a register.
- wb_longLat  in  1  WB write originates from a long-latency op.
- wb_regToWrite  in  REG_ADDR_WIDTH  WB destination register.
- stall  out  1  hold IF/ID, insert bubble into ID/EX (combinational).
- pending_any  out  1  registered; any counter non-zero.
- stall_cycles  out  PERF_WIDTH  registered saturating count of stall cycles.
- underflow_err  out  1  registered sticky; long-latency retire with no matching issue.

Behaviour:
- State: cnt[r], CNT_WIDTH bits, for r = 1..NUM_REGS-1. Register 0 is never tracked; its count reads 0.
- Reset (rst low, async): all cnt = 0, pending_any = 0, stall_cycles = 0, underflow_err = 0. An in-flight dependency is discarded. Reset is also asserted mid-operation on a pipeline flush-all.
- retire = wb_writeReg & wb_longLat & (wb_regToWrite != 0).
- src_hazard(x) = (x != 0) & (cnt[x] != 0) & !(retire & wb_regToWrite == x & cnt[x] == 1).
  - A same-cycle final retire is not a hazard, because the register file write-through plus WB forwarding cover it.
- dest_full = id_writeReg & id_longLat & (id_regToWrite != 0) & (cnt[id_regToWrite] == max) & !(retire & wb_regToWrite == id_regToWrite).
- stall = id_valid & !id_flush & ((id_useRs & src_hazard(id_rs)) | (id_useRt & src_hazard(id_rt)) | dest_full).
- issue = id_valid & !id_flush & !stall & id_writeReg & id_longLat & (id_regToWrite != 0).
- Counter update, per clock edge:
  - issue only: cnt[rd] + 1.
  - retire only: cnt[wb] - 1. If cnt[wb] == 0, cnt stays 0 and underflow_err sets (sticky until reset).
  - issue and retire to the same register: cnt unchanged.
  - issue and retire to different registers: both updates apply.
- Latency: a counter change is visible to stall on the cycle after the issue/retire edge.
- Short-latency writes (id_longLat = 0) never touch counters. The forwarding unit resolves them.
- pending_any <= OR of next-state cnt values.
- stall_cycles: +1 on every cycle with stall = 1; holds at all-ones.
- id_flush wins over stall. A flushed instruction never issues and never stalls.
- Inputs are sampled without registering; outputs other than stall are registered.

Test Plan:
- Reset then idle, all inputs 0 -> stall = 0, pending_any = 0, stall_cycles = 0. Assert rst low mid-run with cnt[8] = 1 -> all cleared asynchronously, before the next clk edge.
- Load issue rd = 8; next cycle ID rs = 8, useRs = 1 -> stall = 1. Hold 2 cycles, then WB retire r8 while ID still reads r8 -> stall = 0 that cycle; cnt[8] = 0 after; stall_cycles = 3.
- Load to r0, then ID reads r0 -> no counter change, stall = 0, pending_any stays 0.
- Two loads to r5 back-to-back (cnt = 2, CNT_WIDTH = 2). A third load to r5 issues (cnt = 3). A fourth load to r5 with no retire -> stall = 1 (dest_full). Same fourth load with a same-cycle r5 retire -> stall = 0, cnt stays 3.
- Issue r9 and retire r9 in the same cycle with cnt[9] = 1 -> cnt[9] stays 1. Issue r9 plus retire r10 -> cnt[9]+1, cnt[10]-1.
- WB long-latency retire r12 with cnt[12] = 0 -> underflow_err = 1 next cycle and stays 1. id_flush with an r8 hazard present -> stall = 0, no issue.
